// File: rtl/lynxTypes.sv
// lynxTypes: shared RDMA types and constants.
//   ack_t                     - RoCE ack/nak record (rd, is_nack, vfid, pid, ssn)
//   coal_state_t              - state encoding of rdma_ack_coalescer
//   RDMA_ACK_COAL_WINDOW_DEF  - default hold window (cycles) of the ack coalescer
//   ack_coal_match()          - two acks may be merged into one cumulative ack
package lynxTypes;

  localparam int N_REGIONS_BITS = 4;
  localparam int PID_BITS       = 6;
  localparam int RDMA_MSN_BITS  = 24;

  localparam int RDMA_ACK_COAL_WINDOW_DEF = 64;

  typedef struct packed {
    logic                      rd;
    logic                      is_nack;
    logic [N_REGIONS_BITS-1:0] vfid;
    logic [PID_BITS-1:0]       pid;
    logic [RDMA_MSN_BITS-1:0]  ssn;
  } ack_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } coal_state_t;

  // Only positive acks of the same flow (vfid, pid, direction) are merged.
  function automatic logic ack_coal_match(input ack_t a, input ack_t b);
    return !a.is_nack && !b.is_nack &&
           (a.vfid == b.vfid) && (a.pid == b.pid) && (a.rd == b.rd);
  endfunction

endpackage

// File: rtl/rdma_ack_coalescer.sv
// rdma_ack_coalescer
//   Folds runs of back-to-back positive acks of the same (vfid, pid, rd) into
//   one cumulative ack carrying the newest ssn. NAKs pass through unmerged and
//   ordering of all delivered acks is preserved. A single pending slot holds
//   the ack being built; it is flushed when MAX_MERGE acks were folded, when
//   it has aged COAL_WINDOW-1 cycles, or when a non-matching ack arrives.
//
// Parameters
//   COAL_WINDOW  max cycles a merged ack is held before a forced flush (>= 2)
//   MAX_MERGE    max input acks folded into one output ack (>= 1)
//
// Ports (the metaIntf valid/ready/data bundles appear as flat signals)
//   aclk, aresetn             clock; asynchronous active-low reset
//   s_meta_valid/ready/data   ack_t stream from the RoCE stack
//   m_meta_valid/ready/data   coalesced ack_t stream to the rx arbiter
//   merged_cnt, flush_cnt     32-bit saturating stats, only present when
//                             RDMA_ACK_COAL_STATS_EN is defined
//
// m_meta_valid/m_meta_data decode registers only; there is no combinational
// path from s_meta to m_meta. s_meta_ready may depend on s_meta_valid/data.
module rdma_ack_coalescer
  import lynxTypes::*;
#(
  parameter int COAL_WINDOW = RDMA_ACK_COAL_WINDOW_DEF,
  parameter int MAX_MERGE   = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_meta_valid,
  output logic        s_meta_ready,
  input  ack_t        s_meta_data,
  output logic        m_meta_valid,
  input  logic        m_meta_ready,
  output ack_t        m_meta_data
`ifdef RDMA_ACK_COAL_STATS_EN
  ,
  output logic [31:0] merged_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int AGE_W = $clog2(COAL_WINDOW);
  localparam int MRG_W = $clog2(MAX_MERGE + 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(COAL_WINDOW - 1);
  localparam logic [MRG_W-1:0] MRG_LAST = MRG_W'(MAX_MERGE);
  localparam logic [MRG_W-1:0] MRG_ONE  = MRG_W'(1);
  // With MAX_MERGE == 1 a positive ack is already complete when loaded.
  localparam bit SINGLE = (MAX_MERGE == 1);

  coal_state_t      state_reg, state_next;
  ack_t             p_data_reg, p_data_next;
  logic [AGE_W-1:0] p_age_reg, p_age_next;
  logic [MRG_W-1:0] p_merges_reg, p_merges_next;

  logic in_match;
  logic absorb;
  logic load;

  always_comb begin
    state_next    = state_reg;
    p_data_next   = p_data_reg;
    p_age_next    = p_age_reg;
    p_merges_next = p_merges_reg;
    s_meta_ready  = 1'b0;
    absorb        = 1'b0;
    load          = 1'b0;
    in_match      = ack_coal_match(s_meta_data, p_data_reg);

    case (state_reg)
      EMPTY: begin
        s_meta_ready = 1'b1;
        load         = s_meta_valid;
      end

      HOLD: begin
        absorb       = s_meta_valid && in_match;
        s_meta_ready = absorb;
        // Age keeps counting across merges so the hold latency stays bounded.
        p_age_next   = p_age_reg + 1'b1;
        if (absorb) begin
          p_data_next.ssn = s_meta_data.ssn;
          p_merges_next   = p_merges_reg + 1'b1;
        end
        // Any flush cause (full, aged out, foreign ack waiting) takes the slot
        // to DRAIN once; a foreign ack stays on s_meta until DRAIN takes it.
        if ((absorb && (p_merges_next == MRG_LAST)) ||
            (p_age_reg == AGE_LAST) ||
            (s_meta_valid && !in_match)) begin
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        s_meta_ready = m_meta_ready;
        if (m_meta_ready) begin
          // Refill on the handshake cycle so a steady stream sees no bubble.
          if (s_meta_valid) begin
            load = 1'b1;
          end else begin
            state_next = EMPTY;
          end
        end
      end

      default: begin
        state_next = EMPTY;
      end
    endcase

    if (load) begin
      p_data_next   = s_meta_data;
      p_age_next    = '0;
      p_merges_next = MRG_ONE;
      state_next    = (s_meta_data.is_nack || SINGLE) ? DRAIN : HOLD;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= EMPTY;
      p_data_reg   <= '0;
      p_age_reg    <= '0;
      p_merges_reg <= '0;
    end else begin
      state_reg    <= state_next;
      p_data_reg   <= p_data_next;
      p_age_reg    <= p_age_next;
      p_merges_reg <= p_merges_next;
    end
  end

  assign m_meta_valid = (state_reg == DRAIN);
  assign m_meta_data  = p_data_reg;

`ifdef RDMA_ACK_COAL_STATS_EN
  if (1) begin : g_stats
    logic merged_inc;
    logic flush_inc;

    assign merged_inc = (state_reg == HOLD) && s_meta_valid && s_meta_ready;
    assign flush_inc  = m_meta_valid && m_meta_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        merged_cnt <= '0;
        flush_cnt  <= '0;
      end else begin
        if (merged_inc && (merged_cnt != '1)) begin
          merged_cnt <= merged_cnt + 1'b1;
        end
        if (flush_inc && (flush_cnt != '1)) begin
          flush_cnt <= flush_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rdma_ack_coalescer.sv
// Self-checking bench for rdma_ack_coalescer (COAL_WINDOW=64, MAX_MERGE=16).
// Stats ports are connected and checked when RDMA_ACK_COAL_STATS_EN is defined.
module tb_rdma_ack_coalescer;
  import lynxTypes::*;

  localparam int CW = 64;
  localparam int MM = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic s_meta_valid, s_meta_ready, m_meta_valid, m_meta_ready;
  ack_t s_meta_data, m_meta_data;
`ifdef RDMA_ACK_COAL_STATS_EN
  logic [31:0] merged_cnt, flush_cnt;
`endif

  rdma_ack_coalescer #(.COAL_WINDOW(CW), .MAX_MERGE(MM)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_meta_valid (s_meta_valid),
    .s_meta_ready (s_meta_ready),
    .s_meta_data  (s_meta_data),
    .m_meta_valid (m_meta_valid),
    .m_meta_ready (m_meta_ready),
    .m_meta_data  (m_meta_data)
`ifdef RDMA_ACK_COAL_STATS_EN
    ,
    .merged_cnt   (merged_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Output monitor: one line per delivered ack.
  ack_t got_q[$];
  int   got_t[$];
  always @(negedge aclk) begin
    if (aresetn && m_meta_valid && m_meta_ready) begin
      got_q.push_back(m_meta_data);
      got_t.push_back(cyc);
      $display("txn out t=%0d nack=%0d rd=%0d vfid=%0d pid=%0d ssn=%0d", cyc,
               m_meta_data.is_nack, m_meta_data.rd, m_meta_data.vfid,
               m_meta_data.pid, m_meta_data.ssn);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ack_t mk(input bit nack, input int vfid, input int pid, input int ssn);
    ack_t a;
    a = '0;
    a.is_nack = nack;
    a.vfid    = N_REGIONS_BITS'(vfid);
    a.pid     = PID_BITS'(pid);
    a.ssn     = RDMA_MSN_BITS'(ssn);
    return a;
  endfunction

  // Reference merge rule: two positive acks of the same flow.
  function automatic bit same_flow(input ack_t a, input ack_t b);
    return (a.is_nack == 1'b0) && (b.is_nack == 1'b0) &&
           (a.vfid == b.vfid) && (a.pid == b.pid) && (a.rd == b.rd);
  endfunction

  task automatic do_reset();
    aresetn      = 1'b0;
    s_meta_valid = 1'b0;
    s_meta_data  = '0;
    m_meta_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    got_q.delete();
    got_t.delete();
  endtask

  // Present one ack until accepted (bounded); returns at posedge+1.
  task automatic send(input ack_t a);
    bit ok;
    ok = 1'b0;
    s_meta_valid = 1'b1;
    s_meta_data  = a;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge aclk);
      ok = s_meta_ready;
      @(posedge aclk);
      #1;
    end
    s_meta_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ssn=%0d not accepted within 300 cycles", a.ssn);
    end
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      @(posedge aclk);
      k++;
    end
    #1;
  endtask

  task automatic measure_latency(input ack_t a, input int exp_lat, input string nm);
    int lat;
    bit found;
    s_meta_valid = 1'b1;
    s_meta_data  = a;
    @(negedge aclk);
    check({nm, "_ready"}, 64'(s_meta_ready), 64'd1);
    @(posedge aclk);
    #1 s_meta_valid = 1'b0;
    lat   = 1;
    found = 1'b0;
    while (!found && lat <= 3 * CW) begin
      @(negedge aclk);
      if (m_meta_valid) found = 1'b1;
      else begin
        @(posedge aclk);
        #1;
        lat++;
      end
    end
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    check({nm, "_data"}, 64'(m_meta_data), 64'(a));
    @(posedge aclk);
    #1;
  endtask

  // Directed per-cycle vectors: ack, NAK, foreign ack ordering.
  typedef struct {
    bit   s_valid;
    ack_t s_data;
    bit   m_ready;
    bit   exp_ready;
    bit   exp_valid;
    ack_t exp_data;
  } vec_t;
  vec_t vecs[5];

  // Reference model state for the random phase.
  ack_t pres_q[$];
  ack_t grp_q[$];
  int   grp_start;
  int   mdl_merged;
  int   mdl_flush;

  task automatic open_grp(input ack_t a, input int t);
    if (a.is_nack || MM == 1) pres_q.push_back(a);
    else begin
      grp_q.delete();
      grp_q.push_back(a);
      grp_start = t + 1;
    end
  endtask

  function automatic ack_t fold_grp();
    ack_t s;
    s     = grp_q[0];
    s.ssn = grp_q[grp_q.size()-1].ssn;
    return s;
  endfunction

  ack_t prev_ack;
  function automatic ack_t rand_ack();
    ack_t a;
    if ($urandom_range(9) < 7) begin
      a = prev_ack;
      a.is_nack = 1'b0;
    end else begin
      a = '0;
      a.rd      = ($urandom_range(7) == 0);
      a.is_nack = ($urandom_range(7) == 0);
      a.vfid    = N_REGIONS_BITS'($urandom_range(1));
      a.pid     = PID_BITS'($urandom_range(1));
    end
    a.ssn = RDMA_MSN_BITS'($urandom);
    return a;
  endfunction

  initial begin
    ack_t a_pos, n_ack, b_pos;
    bit   hold_in, e_valid, e_ready, absorbed;
    int   vprob;

    s_meta_valid = 1'b0;
    s_meta_data  = '0;
    m_meta_ready = 1'b1;
    prev_ack     = '0;

    a_pos = mk(0, 0, 2, 5);
    n_ack = mk(1, 0, 2, 6);
    b_pos = mk(0, 1, 2, 7);
    vecs[0] = '{1'b1, a_pos, 1'b1, 1'b1, 1'b0, ack_t'('0)};
    vecs[1] = '{1'b1, n_ack, 1'b1, 1'b0, 1'b0, ack_t'('0)};
    vecs[2] = '{1'b1, n_ack, 1'b1, 1'b1, 1'b1, a_pos};
    vecs[3] = '{1'b1, b_pos, 1'b1, 1'b1, 1'b1, n_ack};
    vecs[4] = '{1'b0, ack_t'('0), 1'b1, 1'b0, 1'b0, ack_t'('0)};

    // Reset state
    do_reset();
    @(negedge aclk);
    check("rst_ready", 64'(s_meta_ready), 64'd1);
    check("rst_valid", 64'(m_meta_valid), 64'd0);
    check("rst_data", 64'(m_meta_data), 64'd0);
    @(posedge aclk);
    #1;

    // Isolated positive ack and isolated NAK latency
    measure_latency(mk(0, 1, 3, 10), CW + 1, "lat_pos");
    wait_outputs(1, 10);
    check("lat_pos_count", 64'(got_q.size()), 64'd1);
    do_reset();
    measure_latency(mk(1, 1, 3, 11), 1, "lat_nak");

    // Five matching acks fold into one
    do_reset();
    for (int i = 0; i < 5; i++) send(mk(0, 1, 3, 10 + i));
    wait_outputs(1, 3 * CW);
    check("five_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("five_ssn", 64'(got_q[0]), 64'(mk(0, 1, 3, 14)));
`ifdef RDMA_ACK_COAL_STATS_EN
    check("five_merged_cnt", 64'(merged_cnt), 64'd4);
    check("five_flush_cnt", 64'(flush_cnt), 64'd1);
`endif

    // Twenty matching acks: full slot flush then window flush
    do_reset();
    for (int i = 0; i < 20; i++) send(mk(0, 2, 5, 100 + i));
    wait_outputs(2, 3 * CW);
    check("twenty_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() >= 2) begin
      check("twenty_first", 64'(got_q[0]), 64'(mk(0, 2, 5, 115)));
      check("twenty_second", 64'(got_q[1]), 64'(mk(0, 2, 5, 119)));
      check("twenty_gap", 64'(got_t[1] - got_t[0]), 64'(CW + 1));
    end
`ifdef RDMA_ACK_COAL_STATS_EN
    check("twenty_merged_cnt", 64'(merged_cnt), 64'd18);
    check("twenty_flush_cnt", 64'(flush_cnt), 64'd2);
`endif

    // Ack / NAK / foreign ack ordering (table-driven)
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s_meta_valid = vecs[i].s_valid;
      s_meta_data  = vecs[i].s_data;
      m_meta_ready = vecs[i].m_ready;
      @(negedge aclk);
      check($sformatf("vec%0d_ready", i), 64'(s_meta_ready), 64'(vecs[i].exp_ready));
      check($sformatf("vec%0d_valid", i), 64'(m_meta_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), 64'(m_meta_data), 64'(vecs[i].exp_data));
      @(posedge aclk);
      #1;
    end
    s_meta_valid = 1'b0;
    wait_outputs(3, 3 * CW);
    check("order_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() >= 3) begin
      check("order_0", 64'(got_q[0]), 64'(a_pos));
      check("order_1", 64'(got_q[1]), 64'(n_ack));
      check("order_2", 64'(got_q[2]), 64'(b_pos));
    end

    // Back-pressure during DRAIN with a waiting input
    do_reset();
    m_meta_ready = 1'b0;
    send(mk(1, 0, 0, 50));
    s_meta_valid = 1'b1;
    s_meta_data  = mk(1, 0, 0, 51);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("bp_valid", 64'(m_meta_valid), 64'd1);
      check("bp_data", 64'(m_meta_data), 64'(mk(1, 0, 0, 50)));
      check("bp_ready", 64'(s_meta_ready), 64'd0);
      @(posedge aclk);
      #1;
    end
    m_meta_ready = 1'b1;
    @(negedge aclk);
    check("bp_release_ready", 64'(s_meta_ready), 64'd1);
    @(posedge aclk);
    #1 s_meta_valid = 1'b0;
    @(negedge aclk);
    check("bp_reload_valid", 64'(m_meta_valid), 64'd1);
    check("bp_reload_data", 64'(m_meta_data), 64'(mk(1, 0, 0, 51)));
    @(posedge aclk);
    #1;

    // Asynchronous reset while an ack is being presented
    do_reset();
    m_meta_ready = 1'b0;
    send(mk(1, 3, 1, 77));
    @(negedge aclk);
    check("arst_pre_valid", 64'(m_meta_valid), 64'd1);
    #1 aresetn = 1'b0;
    #1;
    check("arst_valid", 64'(m_meta_valid), 64'd0);
    check("arst_ready", 64'(s_meta_ready), 64'd1);
    check("arst_data", 64'(m_meta_data), 64'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    m_meta_ready = 1'b1;

    // Reset mid-HOLD drops the slot; next ack starts a fresh one
    do_reset();
    for (int i = 0; i < 3; i++) send(mk(0, 1, 1, 20 + i));
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check("hrst_valid", 64'(m_meta_valid), 64'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (2 * CW) @(posedge aclk);
    #1;
    check("hrst_dropped", 64'(got_q.size()), 64'd0);
    for (int i = 0; i < MM; i++) send(mk(0, 1, 1, 30 + i));
    wait_outputs(1, 20);
    check("hrst_fresh_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("hrst_fresh_ssn", 64'(got_q[0]), 64'(mk(0, 1, 1, 30 + MM - 1)));
    repeat (2 * CW) @(posedge aclk);
    #1;
    check("hrst_no_extra", 64'(got_q.size()), 64'd1);
`ifdef RDMA_ACK_COAL_STATS_EN
    check("hrst_merged_cnt", 64'(merged_cnt), 64'(MM - 1));
    check("hrst_flush_cnt", 64'(flush_cnt), 64'd1);
`endif

    // Random traffic against the reference model
    do_reset();
    pres_q.delete();
    grp_q.delete();
    grp_start  = 0;
    mdl_merged = 0;
    mdl_flush  = 0;
    hold_in    = 1'b0;
    vprob      = 95;
    for (int t = 0; t < 4000; t++) begin
      if (t % 250 == 0) begin
        case ((t / 250) % 3)
          0:       vprob = 95;
          1:       vprob = 30;
          default: vprob = 2;
        endcase
      end
      if (!hold_in) begin
        s_meta_valid = ($urandom_range(99) < vprob);
        s_meta_data  = rand_ack();
        prev_ack     = s_meta_data;
      end
      m_meta_ready = ($urandom_range(3) != 0);

      e_valid = (pres_q.size() != 0);
      if (e_valid) e_ready = m_meta_ready;
      else if (grp_q.size() != 0)
        e_ready = s_meta_valid && same_flow(s_meta_data, grp_q[grp_q.size()-1]);
      else e_ready = 1'b1;

      @(negedge aclk);
      check("rnd_valid", 64'(m_meta_valid), 64'(e_valid));
      check("rnd_ready", 64'(s_meta_ready), 64'(e_ready));
      if (e_valid) check("rnd_data", 64'(m_meta_data), 64'(pres_q[0]));

      @(posedge aclk);
      if (pres_q.size() != 0) begin
        if (m_meta_ready) begin
          pres_q.delete();
          mdl_flush++;
          if (s_meta_valid) open_grp(s_meta_data, t);
        end
      end else if (grp_q.size() != 0) begin
        absorbed = s_meta_valid && same_flow(s_meta_data, grp_q[grp_q.size()-1]);
        if (absorbed) begin
          grp_q.push_back(s_meta_data);
          mdl_merged++;
        end
        if (grp_q.size() == MM || (t - grp_start) == CW - 1 || (s_meta_valid && !absorbed)) begin
          pres_q.push_back(fold_grp());
          grp_q.delete();
        end
      end else if (s_meta_valid) begin
        open_grp(s_meta_data, t);
      end
      hold_in = s_meta_valid && !e_ready;
      #1;
    end
`ifdef RDMA_ACK_COAL_STATS_EN
    check("rnd_merged_cnt", 64'(merged_cnt), 64'(mdl_merged));
    check("rnd_flush_cnt", 64'(flush_cnt), 64'(mdl_flush));
`endif
    s_meta_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
